// File: rtl/sopc_trace_buffer_pkg.sv
// Shared trace-buffer definitions: FSM encodings, record layout and overflow limit.
// Purely declarative; no timing or flow control of its own.
package sopc_trace_buffer_pkg;

    typedef enum logic [1:0] {
        TR_IDLE = 2'd0,
        TR_RUN  = 2'd1,
        TR_HOLD = 2'd2
    } tr_state_t;

    // A record is {pc, inst, result}, with pc in the most significant field.
    localparam int TR_FIELDS = 3;

    localparam logic [15:0] OVF_MAX = 16'hFFFF;

endpackage

// File: rtl/sopc_trace_buffer_fifo.sv
// Show-ahead DEPTH x WIDTH FIFO; a write is readable one cycle later and the head is combinational.
// Backpressure: a push while full is accepted only alongside a pop; pop when empty is ignored.
module sopc_trace_buffer_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 96
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
        end
    end

    // Storage needs no reset: empty slots are never presented downstream.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sopc_trace_buffer.sv
// Captures a {pc, inst, result} record on every pc change while armed; record visible 1 cycle later.
// Valid/ready drain; when full, new records are dropped and counted, or capture freezes (STOP_ON_FULL).
module sopc_trace_buffer
    import sopc_trace_buffer_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 32,
    parameter int STOP_ON_FULL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] inst_i,
    input  logic [DATA_W-1:0] result_i,
    output logic              tr_valid_o,
    input  logic              tr_ready_i,
    output logic [DATA_W-1:0] tr_pc_o,
    output logic [DATA_W-1:0] tr_inst_o,
    output logic [DATA_W-1:0] tr_res_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic [15:0]       ovf_cnt_o,
    output logic [1:0]        state_o
);

    localparam int              REC_W    = TR_FIELDS * DATA_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    tr_state_t         state;
    tr_state_t         state_nxt;
    logic [DATA_W-1:0] last_pc;
    logic              last_vld;
    logic [REC_W-1:0]  wr_rec;
    logic [REC_W-1:0]  head_rec;
    logic [ADDR_W:0]   fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              cap_evt;
    logic              pop;
    logic              drop;
    logic              hold_go;

    assign cap_evt = (state == TR_RUN) && (!last_vld || (pc_i != last_pc));
    assign pop     = ~fifo_empty & tr_ready_i;
    assign drop    = cap_evt & fifo_full & ~pop;
    // Freeze once this capture leaves the FIFO holding DEPTH records.
    assign hold_go = (STOP_ON_FULL != 0) && cap_evt &&
                     (fifo_full || ((fifo_count == LAST_CNT) && !pop));
    assign wr_rec  = {pc_i, inst_i, result_i};

    sopc_trace_buffer_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_i),
        .push  (cap_evt),
        .pop   (tr_ready_i),
        .wdata (wr_rec),
        .rdata (head_rec),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tr_valid_o = ~fifo_empty;
    assign tr_pc_o    = fifo_empty ? '0 : head_rec[REC_W-1 -: DATA_W];
    assign tr_inst_o  = fifo_empty ? '0 : head_rec[2*DATA_W-1 -: DATA_W];
    assign tr_res_o   = fifo_empty ? '0 : head_rec[DATA_W-1:0];
    assign count_o    = fifo_count;
    assign full_o     = fifo_full;
    assign state_o    = state;

    always_comb begin
        state_nxt = state;
        if (clr_i) begin
            state_nxt = TR_IDLE;
        end else begin
            case (state)
                TR_IDLE: if (en_i) state_nxt = TR_RUN;
                TR_RUN: begin
                    if (!en_i)        state_nxt = TR_IDLE;
                    else if (hold_go) state_nxt = TR_HOLD;
                end
                TR_HOLD: begin
                    if (!en_i)          state_nxt = TR_IDLE;
                    else if (!fifo_full) state_nxt = TR_RUN;
                end
                default: state_nxt = TR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= TR_IDLE;
        else      state <= state_nxt;
    end

    // Entering RUN forgets the last pc so the first sampled cycle is always recorded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pc  <= '0;
            last_vld <= 1'b0;
        end else if (clr_i) begin
            last_vld <= 1'b0;
        end else if ((state != TR_RUN) && (state_nxt == TR_RUN)) begin
            last_vld <= 1'b0;
        end else if (cap_evt) begin
            last_pc  <= pc_i;
            last_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                 ovf_cnt_o <= '0;
        else if (clr_i)                           ovf_cnt_o <= '0;
        else if (drop && (ovf_cnt_o != OVF_MAX))  ovf_cnt_o <= ovf_cnt_o + 16'd1;
    end

endmodule

// File: tb/tb_sopc_trace_buffer.sv
// Two instances (freeze-on-full and drop-on-full) share stimulus; each is checked every cycle
// against a queue-based model, plus directed checks on the listed scenarios.
module tb_sopc_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] inst = '0;
    logic [31:0] res = '0;

    logic        v0, v1, f0, f1;
    logic [31:0] p0, p1, i0, i1, r0, r1;
    logic [4:0]  c0, c1;
    logic [15:0] o0, o1;
    logic [1:0]  s0, s1;

    always #5 clk = ~clk;

    sopc_trace_buffer #(.DEPTH(16), .ADDR_W(4), .DATA_W(32), .STOP_ON_FULL(1)) u0 (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .pc_i(pc), .inst_i(inst), .result_i(res),
        .tr_valid_o(v0), .tr_ready_i(ready), .tr_pc_o(p0), .tr_inst_o(i0), .tr_res_o(r0),
        .count_o(c0), .full_o(f0), .ovf_cnt_o(o0), .state_o(s0));

    sopc_trace_buffer #(.DEPTH(16), .ADDR_W(4), .DATA_W(32), .STOP_ON_FULL(0)) u1 (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .pc_i(pc), .inst_i(inst), .result_i(res),
        .tr_valid_o(v1), .tr_ready_i(ready), .tr_pc_o(p1), .tr_inst_o(i1), .tr_res_o(r1),
        .count_o(c1), .full_o(f1), .ovf_cnt_o(o1), .state_o(s1));

    // Reference model: state 0=IDLE 1=RUN 2=HOLD, stored records in a queue per instance.
    logic [95:0] q0[$];
    logic [95:0] q1[$];
    int          mst[2];
    bit          mlv[2];
    logic [31:0] mlp[2];
    int          movf[2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int m = 0; m < 2; m++) begin
            mst[m]  = 0;
            mlv[m]  = 1'b0;
            mlp[m]  = '0;
            movf[m] = 0;
        end
    endtask

    task automatic model_step(input int m);
        logic [95:0] tq[$];
        bit          stop, p, ev;
        int          st, nst, pre;
        if (m == 0) tq = q0; else tq = q1;
        stop = (m == 0);
        st   = mst[m];
        if (!rst || clr) begin
            tq.delete();
            mst[m]  = 0;
            mlv[m]  = 1'b0;
            movf[m] = 0;
        end else begin
            pre = tq.size();
            p   = (pre > 0) && ready;
            ev  = (st == 1) && (!mlv[m] || pc != mlp[m]);
            if (p) void'(tq.pop_front());
            if (ev) begin
                mlp[m] = pc;
                mlv[m] = 1'b1;
                if (pre < DEPTH || p) tq.push_back({pc, inst, res});
                else if (movf[m] < 65535) movf[m]++;
            end
            nst = st;
            case (st)
                0: if (en) nst = 1;
                1: if (!en) nst = 0;
                   else if (stop && ev && tq.size() == DEPTH) nst = 2;
                default: if (!en) nst = 0;
                         else if (pre < DEPTH) nst = 1;
            endcase
            if (nst == 1 && st != 1) mlv[m] = 1'b0;
            mst[m] = nst;
        end
        if (m == 0) q0 = tq; else q1 = tq;
    endtask

    task automatic chk_dut(input int m, input string pfx, input logic v, input logic [4:0] c,
                           input logic f, input logic [1:0] s, input logic [15:0] o,
                           input logic [31:0] p, input logic [31:0] i, input logic [31:0] r);
        logic [95:0] head;
        int          n;
        n    = (m == 0) ? q0.size() : q1.size();
        head = '0;
        if (n > 0) head = (m == 0) ? q0[0] : q1[0];
        chk({pfx, "_valid"}, 32'(v), 32'(n > 0));
        chk({pfx, "_count"}, 32'(c), 32'(n));
        chk({pfx, "_full"},  32'(f), 32'(n == DEPTH));
        chk({pfx, "_state"}, 32'(s), 32'(mst[m]));
        chk({pfx, "_ovf"},   32'(o), 32'(movf[m]));
        chk({pfx, "_pc"},    p, head[95:64]);
        chk({pfx, "_inst"},  i, head[63:32]);
        chk({pfx, "_res"},   r, head[31:0]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        chk_dut(0, "d0", v0, c0, f0, s0, o0, p0, i0, r0);
        chk_dut(1, "d1", v1, c1, f1, s1, o1, p1, i1, r1);
    endtask

    initial begin
        logic [31:0] seq_pc[5];
        logic [31:0] exp_pc[4];
        logic [31:0] base;
        int          n;
        int          rprob;

        // 1: reset with capture armed, pc held at 0
        model_reset();
        en   = 1'b1;
        inst = $urandom;
        res  = $urandom;
        repeat (2) cycle();
        rst = 1'b1;
        repeat (5) cycle();
        chk("t1_count", 32'(c1), 32'd1);
        chk("t1_pc", p1, 32'h0);

        // 2: short pc sequence with a repeat, no draining
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        pc  = 32'h0;
        cycle();
        seq_pc = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC};
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int k = 0; k < 5; k++) begin
            pc   = seq_pc[k];
            inst = $urandom;
            res  = $urandom;
            cycle();
        end
        chk("t2_count", 32'(c0), 32'd4);
        chk("t2_head", p0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk("t2_order", p1, exp_pc[k]);
            ready = 1'b1;
            cycle();
            ready = 1'b0;
        end
        chk("t2_empty", 32'(c1), 32'd0);

        // 3/4: 20 distinct pcs with no draining
        clr = 1'b1;
        cycle();
        clr  = 1'b0;
        base = {$urandom_range(1, 255), 12'h000, 4'h0} << 4;
        pc   = base;
        cycle();
        for (int k = 0; k < 20; k++) begin
            pc   = base + 32'(k * 4);
            inst = $urandom;
            res  = $urandom;
            cycle();
        end
        chk("t3_count", 32'(c0), 32'd16);
        chk("t3_state", 32'(s0), 32'd2);
        chk("t3_ovf", 32'(o0), 32'd0);
        chk("t4_count", 32'(c1), 32'd16);
        chk("t4_ovf", 32'(o1), 32'd4);
        chk("t4_head", p1, base);
        ready = 1'b1;
        cycle();
        ready = 1'b0;
        n = 0;
        while (s0 != 2'd1 && n < 4) begin
            cycle();
            n++;
        end
        chk("t3_resume", 32'(s0), 32'd1);

        // 5: full FIFO streaming through with a new pc every cycle
        pc = pc + 32'h100;
        cycle();
        chk("t5_prefull", 32'(c1), 32'd16);
        ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            pc   = pc + 32'h4;
            inst = $urandom;
            res  = $urandom;
            cycle();
        end
        ready = 1'b0;
        chk("t5_count", 32'(c1), 32'd16);
        chk("t5_ovf", 32'(o1), 32'd4);

        // randomized traffic with a small pc alphabet so repeats and overflows occur
        rprob = 2;
        for (int k = 0; k < 800; k++) begin
            if (k % 100 == 0) rprob = $urandom_range(0, 4);
            en    = ($urandom % 8) != 0;
            ready = ($urandom % 4) < rprob;
            clr   = ($urandom % 97) == 0;
            pc    = 32'(($urandom % 6) * 4);
            inst  = $urandom;
            res   = $urandom;
            cycle();
        end
        clr   = 1'b0;
        ready = 1'b0;

        // 6: asynchronous reset with 7 records stored, then synchronous clear
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        en  = 1'b1;
        pc  = 32'h100;
        cycle();
        for (int k = 0; k < 7; k++) begin
            pc = 32'h100 + 32'(k * 4);
            cycle();
        end
        en = 1'b0;
        cycle();
        chk("t6_count7", 32'(c1), 32'd7);
        ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(v0), 32'd0);
        chk("t6_rst_count", 32'(c1), 32'd0);
        model_reset();
        cycle();
        rst   = 1'b1;
        ready = 1'b0;
        en    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pc = 32'h200 + 32'(k * 4);
            cycle();
        end
        chk("t6_refill", 32'(c0), 32'd5);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("t6_clr_count", 32'(c0), 32'd0);
        chk("t6_clr_valid", 32'(v1), 32'd0);
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
